// File: rtl/tx_link_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tx_link_pkg
// Purpose  : Definitions shared by the optical-link framer and the matching
//            deframer: the frame state encoding, the SYNC beat pattern and
//            the default lane and word widths.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package tx_link_pkg;

  // Default widths shared by both ends of the link.
  localparam int DEFAULT_LANE_W = 2;
  localparam int DEFAULT_WORD_W = 32;

  // Widest lane that sync_pattern() can describe.
  localparam int LANE_MAX = 64;

  // Frame states. Each state is the beat currently on the lane.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2,
    ST_PAR  = 2'd3
  } tx_state_e;

  // SYNC beat: all ones across the lane. Callers cast the result to their
  // own lane width.
  function automatic logic [LANE_MAX-1:0] sync_pattern(input int width);
    logic [LANE_MAX-1:0] pat;
    pat = '0;
    for (int i = 0; i < LANE_MAX; i++) begin
      pat[i] = (i < width);
    end
    return pat;
  endfunction

endpackage : tx_link_pkg
`default_nettype wire

// File: rtl/lane_parity_acc.sv
`default_nettype none
// ============================================================================
// Module   : lane_parity_acc
// Purpose  : Lane-wide running XOR used to build the parity beat one data
//            beat at a time.
// Ports    : clk  - clock
//            rst  - asynchronous active-high reset, clears the accumulator
//            clr  - synchronous clear (start of a new frame)
//            en   - fold din into the accumulator this cycle
//            din  - lane slice to fold in
//            acc  - accumulated XOR of all slices since the last clear
// Revision : 1.0 - initial release
// ============================================================================
module lane_parity_acc #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] acc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc ^ din;
    end
  end

endmodule : lane_parity_acc
`default_nettype wire

// File: rtl/tx_framer.sv
`default_nettype none
// ============================================================================
// Module   : tx_framer
// Purpose  : Serialises payload words into lane-wide beats for the optical
//            transmitter. Each frame is SYNC, WORD_W/LANE_W data beats (LSB
//            slice first) and a PAR beat holding the XOR of all data slices.
// Ports    : clk        - clock, all state on the rising edge
//            rst        - asynchronous active-high reset
//            in_data    - payload word from the core
//            in_valid   - in_data is valid
//            in_ready   - framer accepts a word this cycle
//            lane_data  - beat to the transmitter tx_in
//            lane_en    - high during SYNC, DATA and PAR beats
//            frame_done - one-cycle pulse on the PAR beat
// Revision : 1.0 - initial release
// ============================================================================
module tx_framer
  import tx_link_pkg::*;
#(
  parameter int LANE_W = DEFAULT_LANE_W,
  parameter int WORD_W = DEFAULT_WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [LANE_W-1:0] lane_data,
  output logic              lane_en,
  output logic              frame_done
);

  localparam int NBEATS = WORD_W / LANE_W;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(NBEATS - 1);
  localparam logic [LANE_W-1:0] SYNC_BEAT = LANE_W'(sync_pattern(LANE_W));

  // A word must split into whole lane beats.
  if ((LANE_W < 1) || (LANE_W > LANE_MAX) || (WORD_W % LANE_W != 0))
  begin : g_width_check
    $error("tx_framer: WORD_W must be a positive multiple of LANE_W");
  end

  tx_state_e          state, state_nxt;
  logic [WORD_W-1:0]  hold, hold_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [LANE_W-1:0]  lane_data_nxt;
  logic               lane_en_nxt;
  logic               frame_done_nxt;
  logic               in_ready_nxt;
  logic               par_clr;
  logic               par_en;
  logic [LANE_W-1:0]  parity;
  logic               accept;

  // in_ready is itself a register, so accept depends on in_valid only
  // through next-state logic and never reaches the lane outputs directly.
  assign accept = in_valid & in_ready;

  lane_parity_acc #(
    .W (LANE_W)
  ) u_parity (
    .clk (clk),
    .rst (rst),
    .clr (par_clr),
    .en  (par_en),
    .din (hold[LANE_W-1:0]),
    .acc (parity)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      hold       <= '0;
      cnt        <= '0;
      lane_data  <= '0;
      lane_en    <= 1'b0;
      frame_done <= 1'b0;
      in_ready   <= 1'b0;
    end else begin
      state      <= state_nxt;
      hold       <= hold_nxt;
      cnt        <= cnt_nxt;
      lane_data  <= lane_data_nxt;
      lane_en    <= lane_en_nxt;
      frame_done <= frame_done_nxt;
      in_ready   <= in_ready_nxt;
    end
  end

  // Next-state logic also decides what the lane shows in the next cycle, so
  // every output leaves a flop. hold[LANE_W-1:0] is always the next slice to
  // send; it shifts right once per data beat.
  always_comb begin
    state_nxt      = state;
    hold_nxt       = hold;
    cnt_nxt        = cnt;
    lane_data_nxt  = '0;
    lane_en_nxt    = 1'b0;
    frame_done_nxt = 1'b0;
    in_ready_nxt   = 1'b0;
    par_clr        = 1'b0;
    par_en         = 1'b0;

    case (state)
      ST_IDLE, ST_PAR: begin
        if (accept) begin
          state_nxt     = ST_SYNC;
          hold_nxt      = in_data;
          par_clr       = 1'b1;
          lane_en_nxt   = 1'b1;
          lane_data_nxt = SYNC_BEAT;
        end else begin
          state_nxt    = ST_IDLE;
          in_ready_nxt = 1'b1;
        end
      end

      ST_SYNC: begin
        state_nxt     = ST_DATA;
        cnt_nxt       = '0;
        lane_en_nxt   = 1'b1;
        lane_data_nxt = hold[LANE_W-1:0];
        hold_nxt      = hold >> LANE_W;
        par_en        = 1'b1;
      end

      ST_DATA: begin
        lane_en_nxt = 1'b1;
        if (cnt == LAST_BEAT) begin
          // The last slice was folded in on the previous edge, so the
          // accumulator already holds the full parity.
          state_nxt      = ST_PAR;
          lane_data_nxt  = parity;
          frame_done_nxt = 1'b1;
          in_ready_nxt   = 1'b1;
        end else begin
          cnt_nxt       = cnt + CNT_W'(1);
          lane_data_nxt = hold[LANE_W-1:0];
          hold_nxt      = hold >> LANE_W;
          par_en        = 1'b1;
        end
      end

      default: begin
        state_nxt    = ST_IDLE;
        in_ready_nxt = 1'b1;
      end
    endcase
  end

endmodule : tx_framer
`default_nettype wire
